seq_multiplier: RTL and testbench

Parametrised sequential shift-and-add multiplier; successor to the team's fixed 3×3 combinational array multiplier. Multiplies two WIDTH-bit operands over WIDTH clock cycles using one adder, trading latency for area. Optional signed (two's-complement) mode. Sits behind a start/done handshake for use by datapath controllers that previously instantiated combinational multipliers.

---
 rtl/seq_mul_pkg.sv | 20 ++
 rtl/seq_mul_if.sv | 16 +
 rtl/seq_mul_step.sv | 20 ++
 rtl/seq_multiplier.sv | 101 ++++++++++
 tb/tb_seq_multiplier.sv | 132 +++++++++++++
 5 files changed

// File: rtl/seq_mul_pkg.sv
// seq_mul_pkg: shared FSM state encoding and a counter-width helper for seq_multiplier
// Ports: none (package).
package seq_mul_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Bits needed to count 0..v-1, never less than one.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/seq_mul_if.sv
// seq_mul_if: start/done handshake and operand/product bus of seq_multiplier
// Ports: start, a, b, sgn (requester -> multiplier); ready, busy, done, p (multiplier -> requester).
// Modports: master (requester side), slave (multiplier side).
interface seq_mul_if #(parameter int WIDTH = 8);
    logic                 start;
    logic                 sgn;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 ready;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   p;

    modport master (output start, a, b, sgn, input ready, busy, done, p);
    modport slave  (input start, a, b, sgn, output ready, busy, done, p);
endinterface

// File: rtl/seq_mul_step.sv
// seq_mul_step: one combinational shift-and-add step of the multiplier
// Ports: acc (upper accumulator half), mplr_rest (multiplier bits above the LSB),
//        mcand (multiplicand), lsb (multiplier LSB), nxt (next shifted {acc, mplr}).
module seq_mul_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]   acc,
    input  logic [WIDTH-1:1]   mplr_rest,
    input  logic [WIDTH-1:0]   mcand,
    input  logic               lsb,
    output logic [2*WIDTH-1:0] nxt
);
    logic [WIDTH:0] sum;

    // WIDTH+1-bit add so the carry-out shifts into the accumulator MSB.
    always_comb begin
        sum = {1'b0, acc} + (lsb ? {1'b0, mcand} : '0);
        nxt = {sum, mplr_rest};
    end
endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: parametrised sequential shift-and-add multiplier behind a start/done handshake
// Ports: clk (rising edge), rst_n (synchronous, active-low), bus (seq_mul_if.slave:
//        start/a/b/sgn in, ready/busy/done/p out; p is 2*WIDTH bits).
// Config: define SEQ_MUL_SIGNED_EN to honour sgn (two's-complement operands and product);
//         otherwise sgn is ignored and every operation is unsigned.
module seq_multiplier
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    seq_mul_if.slave  bus
);
    localparam int CW = clog2(WIDTH);

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [2*WIDTH-1:0] step;
    logic [2*WIDTH-1:0] res;
    logic [WIDTH-1:0]   a_in, b_in;
    logic               accept;

    seq_mul_step #(.WIDTH(WIDTH)) u_step (
        .acc       (acc_q[2*WIDTH-1:WIDTH]),
        .mplr_rest (acc_q[WIDTH-1:1]),
        .mcand     (mcand_q),
        .lsb       (acc_q[0]),
        .nxt       (step)
    );

`ifdef SEQ_MUL_SIGNED_EN
    logic neg_q, neg_d;

    // Signed operations run on magnitudes; the product sign is reapplied at completion.
    always_comb begin
        a_in  = (bus.sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        b_in  = (bus.sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        neg_d = accept ? (bus.sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1])) : neg_q;
        res   = neg_q ? -step : step;
    end

    always_ff @(posedge clk)
        if (!rst_n) neg_q <= 1'b0;
        else        neg_q <= neg_d;
`else
    always_comb begin
        a_in = bus.a;
        b_in = bus.b;
        res  = step;
    end
`endif

    always_comb begin
        accept  = bus.start && state_q != S_CALC;
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        p_d     = p_q;
        if (accept) begin
            state_d = S_CALC;
            cnt_d   = '0;
            acc_d   = {{WIDTH{1'b0}}, b_in};
            mcand_d = a_in;
        end else if (state_q == S_CALC) begin
            acc_d = step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
                state_d = S_DONE;
                cnt_d   = '0;
                p_d     = res;
            end
        end else if (state_q == S_DONE) begin
            state_d = S_IDLE;
        end
        bus.ready = state_q != S_CALC;
        bus.busy  = state_q == S_CALC;
        bus.done  = state_q == S_DONE;
        bus.p     = p_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            p_q     <= p_d;
        end
    end
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed self-checking bench for seq_multiplier with WIDTH=8
module tb_seq_multiplier;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [15:0] last_p = 16'h0000;

    seq_mul_if #(.WIDTH(8)) bus ();

    seq_multiplier #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an operation, then follow it to its done cycle. Optionally pulse a
    // bogus start during CALC, which must be ignored.
    task automatic run(input logic [7:0] ra, input logic [7:0] rb, input logic rs,
                       input logic [15:0] ep, input bit glitch);
        bus.a     = ra;
        bus.b     = rb;
        bus.sgn   = rs;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.a     = 8'hAA;
        bus.b     = 8'h55;
        bus.sgn   = ~rs;
        for (int i = 1; i <= 8; i++) begin
            if (glitch && i == 3) begin
                bus.start = 1'b1;
                bus.a     = 8'h01;
                bus.b     = 8'h01;
            end
            tick();
            bus.start = 1'b0;
            if (i == 4) begin
                check("busy_mid", {31'b0, bus.busy}, 32'd1);
                check("p_hold", {16'b0, bus.p}, {16'b0, last_p});
            end
            if (i == 7) check("done_early", {31'b0, bus.done}, 32'd0);
        end
        check("done", {31'b0, bus.done}, 32'd1);
        check("product", {16'b0, bus.p}, {16'b0, ep});
        last_p = ep;
    endtask

    task automatic idle_check();
        tick();
        check("done_pulse", {31'b0, bus.done}, 32'd0);
        check("ready_idle", {31'b0, bus.ready}, 32'd1);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
        bus.sgn   = 1'b0;
        tick();
        tick();
        check("rst_ready", {31'b0, bus.ready}, 32'd1);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_p", {16'b0, bus.p}, 32'h0);
        rst_n = 1'b1;
        tick();

        run(8'd13, 8'd11, 1'b0, 16'h008F, 1'b0);
        idle_check();
        run(8'd255, 8'd255, 1'b0, 16'hFE01, 1'b0);
        idle_check();
        run(8'd0, 8'd200, 1'b0, 16'h0000, 1'b0);
        idle_check();
`ifdef SEQ_MUL_SIGNED_EN
        run(8'hFD, 8'h05, 1'b1, 16'hFFF1, 1'b0);
        idle_check();
        run(8'h80, 8'h80, 1'b1, 16'h4000, 1'b0);
        idle_check();
        run(8'h80, 8'h01, 1'b1, 16'hFF80, 1'b0);
        idle_check();
`else
        run(8'hFD, 8'h05, 1'b1, 16'h04F1, 1'b0);
        idle_check();
        run(8'h80, 8'h80, 1'b1, 16'h4000, 1'b0);
        idle_check();
        run(8'h80, 8'h01, 1'b1, 16'h0080, 1'b0);
        idle_check();
`endif
        run(8'd7, 8'd9, 1'b0, 16'h003F, 1'b1);
        run(8'd2, 8'd3, 1'b0, 16'h0006, 1'b0);
        idle_check();

        bus.a     = 8'd9;
        bus.b     = 8'd9;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_busy", {31'b0, bus.busy}, 32'd0);
        check("mid_rst_ready", {31'b0, bus.ready}, 32'd1);
        check("mid_rst_p", {16'b0, bus.p}, 32'h0);
        last_p = 16'h0000;
        for (int i = 0; i < 9; i++) begin
            tick();
            check("mid_rst_no_done", {31'b0, bus.done}, 32'd0);
        end
        run(8'd6, 8'd7, 1'b0, 16'h002A, 1'b0);
        idle_check();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
